// File: rtl/seven_segment_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with once-per-frame data capture.
// Optional anode-off guard at the start of each slot: define SSEG_GHOST_GUARD_EN.
module seven_segment_scan_ctrl #(
    parameter int unsigned REFRESH_BITS = 17,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [7:0]  segment,
    output logic [3:0]  anode
);

`ifdef SSEG_GHOST_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0]              idx;
    logic [15:0]             data_sh;
    logic [3:0]              dp_sh;
    logic [3:0]              blank_sh;

    logic        load_c;
    logic [15:0] data_eff_c;
    logic [3:0]  dp_eff_c;
    logic [3:0]  blank_eff_c;
    logic [3:0]  nibble_c;
    logic        guard_c;
    logic [3:0]  anode_nxt_c;
    logic [7:0]  segment_nxt_c;

    // Hex to active-low segments, bit order g..a.
    function automatic logic [6:0] decode(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // In the load cycle the live inputs drive the pins so the first slot is not stale.
    always_comb begin
        load_c        = (cnt == '0) && (idx == 2'd0);
        data_eff_c    = load_c ? data_in : data_sh;
        dp_eff_c      = load_c ? dp_in   : dp_sh;
        blank_eff_c   = load_c ? blank   : blank_sh;
        nibble_c      = data_eff_c[{idx, 2'b00} +: 4];
        guard_c       = GUARD_EN && (cnt < REFRESH_BITS'(GUARD_CYCLES));
        anode_nxt_c   = 4'hF;
        segment_nxt_c = 8'hFF;
        if (!guard_c) begin
            anode_nxt_c   = blank_eff_c[idx] ? 4'hF : ~(4'b0001 << idx);
            segment_nxt_c = {~dp_eff_c[idx], decode(nibble_c)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            idx      <= 2'd0;
            data_sh  <= 16'h0000;
            dp_sh    <= 4'h0;
            blank_sh <= 4'h0;
            anode    <= 4'hF;
            segment  <= 8'hFF;
        end else begin
            cnt <= cnt + REFRESH_BITS'(1);
            if (&cnt) begin
                idx <= idx + 2'd1;
            end
            if (load_c) begin
                data_sh  <= data_in;
                dp_sh    <= dp_in;
                blank_sh <= blank;
            end
            anode   <= anode_nxt_c;
            segment <= segment_nxt_c;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for seven_segment_scan_ctrl with 8-cycle slots; frame-level reference model.
module tb_seven_segment_scan_ctrl;

    localparam int unsigned RB    = 3;
    localparam int unsigned GC    = 2;
    localparam int unsigned SLOT  = 8;
    localparam int unsigned FRAME = 32;
`ifdef SSEG_GHOST_GUARD_EN
    localparam int unsigned GUARD = GC;
`else
    localparam int unsigned GUARD = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [7:0]  segment;
    logic [3:0]  anode;

    always #5 clk = ~clk;

    seven_segment_scan_ctrl #(.REFRESH_BITS(RB), .GUARD_CYCLES(GC)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .dp_in   (dp_in),
        .blank   (blank),
        .segment (segment),
        .anode   (anode)
    );

    int checks = 0;
    int passes = 0;

    // Model: cycles elapsed since reset release and the frame's captured inputs.
    int unsigned t = 0;
    logic [15:0] cap_d  = 16'h0000;
    logic [3:0]  cap_dp = 4'h0;
    logic [3:0]  cap_bl = 4'h0;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic [6:0]  font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Predict the pins after the coming edge, then clock it and settle.
    task automatic step();
        int unsigned slot;
        int unsigned ph;
        if (reset) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
            t       = 0;
        end else begin
            if (t % FRAME == 0) begin
                cap_d  = data_in;
                cap_dp = dp_in;
                cap_bl = blank;
            end
            slot = (t / SLOT) % 4;
            ph   = t % SLOT;
            if (ph < GUARD) begin
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
            end else begin
                exp_an  = cap_bl[slot] ? 4'hF : ~4'(1 << slot);
                exp_seg = {~cap_dp[slot], font[cap_d[slot*4 +: 4]]};
            end
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        data_in = 16'h1234;
        reset   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (anode !== 4'hF || segment !== 8'hFF)
                $display("FAIL reset_hold cyc=%0d anode=%b seg=%h want anode=1111 seg=ff", i, anode, segment);
            else passes++;
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (anode !== exp_an || segment !== exp_seg)
                $display("FAIL reset_release cyc=%0d anode=%b seg=%b want anode=%b seg=%b", i, anode, segment, exp_an, exp_seg);
            else passes++;
        end
    endtask

    task automatic test_frame_walk();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if (anode !== exp_an || segment !== exp_seg)
                $display("FAIL frame_walk cyc=%0d anode=%b seg=%b want anode=%b seg=%b", i, anode, segment, exp_an, exp_seg);
            else passes++;
        end
    endtask

    task automatic test_mid_frame_update();
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != SLOT + 2; i++) step();
        data_in = 16'hFFFF;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if (anode !== exp_an || segment !== exp_seg)
                $display("FAIL mid_frame cyc=%0d anode=%b seg=%b want anode=%b seg=%b", i, anode, segment, exp_an, exp_seg);
            else passes++;
        end
    endtask

    task automatic test_blank_dp();
        data_in = 16'h1234;
        blank   = 4'b0100;
        dp_in   = 4'b0001;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            checks++;
            if (anode !== exp_an || segment !== exp_seg)
                $display("FAIL blank_dp cyc=%0d anode=%b seg=%b want anode=%b seg=%b", i, anode, segment, exp_an, exp_seg);
            else passes++;
        end
        blank = 4'b1111;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if (anode !== exp_an || segment !== exp_seg)
                $display("FAIL blank_all cyc=%0d anode=%b seg=%b want anode=%b seg=%b", i, anode, segment, exp_an, exp_seg);
            else passes++;
        end
        blank = 4'b0000;
        dp_in = 4'b0000;
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != 2 * SLOT + 3; i++) step();
        reset   = 1'b1;
        data_in = 16'h5A3C;
        step();
        checks++;
        if (anode !== 4'hF || segment !== 8'hFF)
            $display("FAIL reset_mid anode=%b seg=%h want anode=1111 seg=ff", anode, segment);
        else passes++;
        reset = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            checks++;
            if (anode !== exp_an || segment !== exp_seg)
                $display("FAIL reset_mid_restart cyc=%0d anode=%b seg=%b want anode=%b seg=%b", i, anode, segment, exp_an, exp_seg);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) data_in = 16'($urandom);
            if ($urandom_range(9) == 0) dp_in   = 4'($urandom);
            if ($urandom_range(9) == 0) blank   = 4'($urandom);
            reset = ($urandom_range(79) == 0);
            step();
            checks++;
            if (anode !== exp_an || segment !== exp_seg)
                $display("FAIL random cyc=%0d anode=%b seg=%b want anode=%b seg=%b", i, anode, segment, exp_an, exp_seg);
            else passes++;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_walk();
        test_mid_frame_update();
        test_blank_dp();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
